uart_tx_buffer: RTL

Transmit-side byte buffer between the APB register interface and `transmitter_controller`. It queues bytes written by the bus, pops one byte at a time into a stable holding register, and issues `start_tx` to the transmitter. After `tx_finish`, it issues the next start at the earliest cycle the transmitter controller can accept it. Status (full/empty/level/overflow) is exported to the APB status register.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-buffer FSM states and the default frame width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } tx_buf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with explicit occupancy counter and synchronous flush.
// Latency: a push is visible on pop_data_o/empty_o/count_o one cycle later.
// Backpressure: push refused when full unless a pop retires an entry the same cycle.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   push_i, push_data_i  push strobe and data
//   pop_i                pop strobe (ignored while empty)
//   pop_data_o           head entry, valid while !empty_o
//   flush_i              zero pointers and count; wins over push and pop
//   push_ok_o            push_i was accepted this cycle
//   full_o, empty_o      count == DEPTH, count == 0
//   count_o              occupancy
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      push_data_i,
  input  logic                       pop_i,
  output logic [DATA_WIDTH-1:0]      pop_data_o,
  input  logic                       flush_i,
  output logic                       push_ok_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop_ok;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

  // A pop in the same cycle frees the slot the push is about to take.
  assign push_ok_o = push_i && !flush_i && (!full_o || pop_ok);
  assign pop_ok    = pop_i && !empty_o && !flush_i;

  assign pop_data_o = mem[rd_ptr];

  // Storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok_o) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)    rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok_o, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit byte buffer: queues bus writes, holds one byte stable per frame, issues start_tx.
// Latency: push at k -> start_tx_o at k+2; tx_finish_i at N -> next start_tx_o at N+2.
// Backpressure: writes while full are dropped and flagged by sticky overflow_o.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   wr_en_i, wr_data_i      TXDATA write strobe and byte
//   flush_i                 drop queued bytes (and an unstarted held byte)
//   clr_overflow_i          clear sticky overflow
//   tx_en_i                 transmitter enable
//   tx_finish_i             frame-done pulse from the transmitter controller
//   start_tx_o, tx_data_o   start pulse and held frame byte
//   tx_busy_o               a frame is being loaded or sent
//   full_o, empty_o,
//   count_o, overflow_o     status for the APB status register
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic                       flush_i,
  input  logic                       clr_overflow_i,
  input  logic                       tx_en_i,
  input  logic                       tx_finish_i,
  output logic                       start_tx_o,
  output logic [DATA_WIDTH-1:0]      tx_data_o,
  output logic                       tx_busy_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  tx_buf_state_t         state;
  tx_buf_state_t         state_nxt;
  logic                  hold_valid;
  logic                  pop;
  logic                  push_ok;
  logic [DATA_WIDTH-1:0] head_data;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (wr_en_i),
    .push_data_i (wr_data_i),
    .pop_i       (pop),
    .pop_data_o  (head_data),
    .flush_i     (flush_i),
    .push_ok_o   (push_ok),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // start_tx_o is the LOAD state qualified by the enable level: dropping the
  // enable in LOAD must suppress the pulse so the held byte is retried later.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    start_tx_o = 1'b0;
    case (state)
      IDLE: begin
        // A flush in IDLE also empties the queue, so no load is started.
        if (tx_en_i && !flush_i && (hold_valid || !empty_o)) begin
          state_nxt = LOAD;
          pop       = !hold_valid;
        end
      end
      LOAD: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (tx_en_i) begin
          start_tx_o = 1'b1;
          state_nxt  = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (tx_finish_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_data_o only moves on the pop edge, so it is stable for the whole frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_o  <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (pop) begin
        tx_data_o  <= head_data;
        hold_valid <= 1'b1;
      end
      if ((state == BUSY && tx_finish_i) || (flush_i && state != BUSY)) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // A dropped write sets the flag even if a clear arrives in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_o <= 1'b0;
    end else if (wr_en_i && !flush_i && !push_ok) begin
      overflow_o <= 1'b1;
    end else if (clr_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  assign tx_busy_o = (state != IDLE);

endmodule
